// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i pipeline: hazard controller FSM states and forwarding selects.
package rv32i_pkg;

  localparam int unsigned DPW = 32;

  typedef enum logic [1:0] {
    INIT     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10,
    ERROR    = 2'b11
  } hazard_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// Execute-stage operand forwarding select for one source register.
module fwd_sel_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned ADW = 5
) (
  input  logic [ADW-1:0] RsE,
  input  logic [ADW-1:0] RdM,
  input  logic [ADW-1:0] RdW,
  input  logic           regwriteM,
  input  logic           regwriteW,
  output fwd_sel_t       fwd_o
);

  // The memory-stage result is younger than writeback, so it wins.
  always_comb begin
    fwd_o = FWD_RF;
    if (regwriteM && (RdM != '0) && (RdM == RsE)) begin
      fwd_o = FWD_M;
    end else if (regwriteW && (RdW != '0) && (RdW == RsE)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding sequencer for the 5-stage rv32i pipeline with memory-wait watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned ADW         = 5,
  parameter int unsigned INIT_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [ADW-1:0] Rs1D,
  input  logic [ADW-1:0] Rs2D,
  input  logic [ADW-1:0] Rs1E,
  input  logic [ADW-1:0] Rs2E,
  input  logic [ADW-1:0] RdE,
  input  logic [ADW-1:0] RdM,
  input  logic [ADW-1:0] RdW,
  input  logic           regwriteM,
  input  logic           regwriteW,
  input  logic           resultsrcE,
  input  logic           PCSrcE,
  input  logic           mem_req_M,
  input  logic           mem_ready,
  output logic           stallF,
  output logic           stallD,
  output logic           stallE,
  output logic           stallM,
  output logic           flushD,
  output logic           flushE,
  output logic [1:0]     forwardAE,
  output logic [1:0]     forwardBE,
  output logic           mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [DPW-1:0] perf_stall_cycles,
  output logic [DPW-1:0] perf_flush_count
`endif
);

  localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
  localparam logic [InitW-1:0] InitLast = InitW'(INIT_CYCLES - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  hazard_state_t    state_q;
  logic [InitW-1:0] init_cnt_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             mem_timeout_q;

  fwd_sel_t fwd_a, fwd_b;
  fwd_sel_t fwd_a_out, fwd_b_out;
  logic     lw_stall, busy, freeze;

  fwd_sel_unit #(
    .ADW(ADW)
  ) u_fwd_a (
    .RsE      (Rs1E),
    .RdM      (RdM),
    .RdW      (RdW),
    .regwriteM(regwriteM),
    .regwriteW(regwriteW),
    .fwd_o    (fwd_a)
  );

  fwd_sel_unit #(
    .ADW(ADW)
  ) u_fwd_b (
    .RsE      (Rs2E),
    .RdM      (RdM),
    .RdW      (RdW),
    .regwriteM(regwriteM),
    .regwriteW(regwriteW),
    .fwd_o    (fwd_b)
  );

  assign lw_stall = resultsrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign busy     = mem_req_M && !mem_ready;
  // In MEM_WAIT only mem_ready releases the freeze; mem_req_M is held by the stalled M stage.
  assign freeze   = (state_q == MEM_WAIT) ? !mem_ready : busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      init_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (init_cnt_q == InitLast) begin
            state_q <= RUN;
          end else begin
            init_cnt_q <= init_cnt_q + InitW'(1);
          end
        end
        RUN: begin
          if (busy) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q <= RUN;
          end else if (wait_cnt_q == WaitLast) begin
            state_q       <= ERROR;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        ERROR: begin
          mem_timeout_q <= 1'b1;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    fwd_a_out = FWD_RF;
    fwd_b_out = FWD_RF;
    unique case (state_q)
      INIT: begin
        stallF = 1'b1;
        flushD = 1'b1;
        flushE = 1'b1;
      end
      RUN, MEM_WAIT: begin
        fwd_a_out = fwd_a;
        fwd_b_out = fwd_b;
        if (freeze) begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
        end else begin
          stallF = lw_stall;
          stallD = lw_stall;
          flushD = PCSrcE;
          flushE = lw_stall | PCSrcE;
        end
      end
      ERROR: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end
      default: ;
    endcase
  end

  assign forwardAE   = fwd_a_out;
  assign forwardBE   = fwd_b_out;
  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
  logic           perf_active;
  logic [DPW-1:0] perf_stall_q, perf_flush_q;

  assign perf_active = (state_q == RUN) || (state_q == MEM_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (perf_active && stallD && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + DPW'(1);
      end
      if (perf_active && flushD && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + DPW'(1);
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned ADW   = 5;
  localparam int unsigned INITC = 3;
  localparam int unsigned MTO   = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [ADW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic           regwriteM, regwriteW, resultsrcE, PCSrcE, mem_req_M, mem_ready;
  logic           stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout;
  logic [1:0]     forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0]    perf_stall_cycles, perf_flush_count;
`endif

  int checks = 0;
  int errors = 0;

  // Model: mode 0=init 1=run 2=mem wait 3=error
  int   m_mode, m_init, m_wait;
  logic m_to;
  logic [10:0] last_act;

  pipeline_hazard_ctrl #(
    .ADW        (ADW),
    .INIT_CYCLES(INITC),
    .MEM_TIMEOUT(MTO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .regwriteM  (regwriteM),
    .regwriteW  (regwriteW),
    .resultsrcE (resultsrcE),
    .PCSrcE     (PCSrcE),
    .mem_req_M  (mem_req_M),
    .mem_ready  (mem_ready),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .stallM     (stallM),
    .flushD     (flushD),
    .flushE     (flushE),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_fwd(input logic [ADW-1:0] rs);
    if (regwriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (regwriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Packed as {stallF, stallD, stallE, stallM, flushD, flushE, fwdA, fwdB, mem_timeout}
  function automatic logic [10:0] ref_out();
    logic lw, frz, sf, sd, se, sm, fd, fe;
    logic [1:0] fa, fb;
    lw = resultsrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    {sf, sd, se, sm, fd, fe, fa, fb} = '0;
    case (m_mode)
      0: {sf, fd, fe} = 3'b111;
      1, 2: begin
        fa = ref_fwd(Rs1E);
        fb = ref_fwd(Rs2E);
        frz = (m_mode == 1) ? (mem_req_M && !mem_ready) : !mem_ready;
        if (frz) {sf, sd, se, sm} = 4'b1111;
        else begin
          sf = lw;
          sd = lw;
          fd = PCSrcE;
          fe = lw | PCSrcE;
        end
      end
      default: {sf, sd, se, sm} = 4'b1111;
    endcase
    return {sf, sd, se, sm, fd, fe, fa, fb, m_to};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_init = 0;
    m_wait = 0;
    m_to   = 1'b0;
  endtask

  task automatic model_advance();
    case (m_mode)
      0: begin
        if (m_init == INITC - 1) m_mode = 1;
        m_init++;
      end
      1: if (mem_req_M && !mem_ready) begin
        m_mode = 2;
        m_wait = 0;
      end
      2: begin
        if (mem_ready) m_mode = 1;
        else if (m_wait == MTO - 1) begin
          m_mode = 3;
          m_to   = 1'b1;
        end else m_wait++;
      end
      default: ;
    endcase
  endtask

  task automatic step_check(input string name);
    logic [10:0] act, exp;
    @(negedge clk);
    exp = ref_out();
    act = {stallF, stallD, stallE, stallM, flushD, flushE, forwardAE, forwardBE, mem_timeout};
    last_act = act;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (sF sD sE sM fD fE fA fB to)", name, act, exp);
    end
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {regwriteM, regwriteW, resultsrcE, PCSrcE, mem_req_M, mem_ready} = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n_init;
    set_idle();
    apply_reset();
    n_init = 0;
    for (int i = 0; i < 6; i++) begin
      step_check("reset_seq");
      if (last_act[10] && last_act[6] && last_act[5]) n_init++;
    end
    checks++;
    if (n_init != INITC) begin
      errors++;
      $display("FAIL init_len: got %0d cycles expected %0d", n_init, INITC);
    end
  endtask

  task automatic test_forwarding();
    set_idle();
    Rs1E = 5; RdM = 5; RdW = 5; regwriteM = 1; regwriteW = 1;
    step_check("fwd_m");
    regwriteM = 0;
    step_check("fwd_w");
    RdM = 0; RdW = 0; regwriteM = 1;
    step_check("fwd_zero");
    Rs2E = 9; RdW = 9; regwriteW = 1;
    step_check("fwd_b_w");
    set_idle();
  endtask

  task automatic test_load_use();
    set_idle();
    resultsrcE = 1; RdE = 7; Rs2D = 7;
    step_check("lw_stall");
    RdE = 0;
    step_check("lw_x0");
    set_idle();
  endtask

  task automatic test_branch();
    set_idle();
    PCSrcE = 1;
    step_check("branch");
    PCSrcE = 0;
    step_check("branch_after");
    resultsrcE = 1; RdE = 3; Rs1D = 3; PCSrcE = 1;
    step_check("branch_lw");
    set_idle();
  endtask

  task automatic test_mem_wait();
    set_idle();
    mem_req_M = 1; PCSrcE = 1; Rs1E = 4; RdM = 4; regwriteM = 1;
    for (int i = 0; i < 4; i++) step_check("mem_freeze");
    mem_ready = 1;
    step_check("mem_release");
    set_idle();
    step_check("mem_run");
  endtask

  task automatic test_timeout();
    set_idle();
    mem_req_M = 1;
    for (int i = 0; i < 1 + MTO; i++) step_check("to_wait");
    for (int i = 0; i < 3; i++) step_check("to_error");
    set_idle();
    step_check("to_sticky");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({mem_timeout, stallF, flushD, flushE, stallD} !== 5'b01110) begin
      errors++;
      $display("FAIL async_rst: got %b expected 01110 (to sF fD fE sD)",
               {mem_timeout, stallF, flushD, flushE, stallD});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < INITC + 1; i++) step_check("post_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 3) begin
        set_idle();
        apply_reset();
      end
      Rs1D = ADW'($urandom_range(0, 3));
      Rs2D = ADW'($urandom_range(0, 3));
      Rs1E = ADW'($urandom_range(0, 3));
      Rs2E = ADW'($urandom_range(0, 3));
      RdE  = ADW'($urandom_range(0, 3));
      RdM  = ADW'($urandom_range(0, 3));
      RdW  = ADW'($urandom_range(0, 3));
      regwriteM  = 1'($urandom_range(0, 1));
      regwriteW  = 1'($urandom_range(0, 1));
      resultsrcE = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      mem_req_M  = ($urandom_range(0, 3) == 0);
      mem_ready  = ($urandom_range(0, 9) < 6);
      step_check("random");
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the 5-stage rv32i pipeline (fetch, decode, execute, memory, writeback); sits beside the stage registers.
- Generates per-stage stall/flush and execute-stage forwarding selects.
- Runs a post-reset pipeline-clearing sequence.
- Freezes the pipeline while the data memory is busy, with a timeout watchdog.
- Replaces ad-hoc tie-offs of stallD/flushD/flushE in the pipeline top.

Parameters:
ADW, 5, register address width
INIT_CYCLES, 3, cycles of forced flush after reset release (>=1)
MEM_TIMEOUT, 16, max MEM_WAIT cycles before error (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
Rs1D, Rs2D  in  ADW  decode-stage source addresses
Rs1E, Rs2E  in  ADW  execute-stage source addresses
RdE, RdM, RdW  in  ADW  destination addresses, E/M/W stages
regwriteM, regwriteW  in  1  register write enables, M/W stages
resultsrcE  in  1  1 = load in execute
PCSrcE  in  1  branch/jump taken in execute
mem_req_M  in  1  memory-stage access (load or store) valid
mem_ready  in  1  data memory completes access this cycle
stallF, stallD, stallE, stallM  out  1  hold stage register
flushD, flushE  out  1  clear stage register
forwardAE, forwardBE  out  2  00 regfile, 01 W result, 10 M aluresult
mem_timeout  out  1  sticky memory watchdog error

Behaviour:
- FSM states INIT, RUN, MEM_WAIT, ERROR. Registers: state, init_cnt, wait_cnt, mem_timeout; all other outputs are combinational from state and inputs.
- Reset (async, any state, mid-operation included): state=INIT, init_cnt=0, wait_cnt=0, mem_timeout=0.
- INIT outputs: stallF=1, flushD=1, flushE=1, stallD=stallE=stallM=0, forwardAE=forwardBE=00.
  - init_cnt increments each cycle.
  - Goes to RUN after INIT_CYCLES cycles, i.e. on the cycle init_cnt==INIT_CYCLES-1.
- Forwarding (RUN and MEM_WAIT), shown for A; B is identical using Rs2E:
  - 10 if regwriteM && RdM!=0 && RdM==Rs1E.
  - else 01 if regwriteW && RdW!=0 && RdW==Rs1E.
  - else 00. M has priority over W.
- lwStall = resultsrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- busy = mem_req_M && !mem_ready.
- RUN, busy=0:
  - stallF=stallD=lwStall; stallE=stallM=0.
  - flushD=PCSrcE; flushE=lwStall|PCSrcE.
  - Load-use and branch in the same cycle: stallF=stallD=1, flushD=flushE=1.
- RUN, busy=1: all four stalls=1, flushD=flushE=0 (memory freeze overrides branch and load-use). Next state MEM_WAIT, wait_cnt=0.
- MEM_WAIT, mem_ready=0: all stalls=1, no flushes, wait_cnt+1.
  - If wait_cnt==MEM_TIMEOUT-1: next state ERROR.
- MEM_WAIT, mem_ready=1: outputs exactly as RUN busy=0 this cycle; next state RUN.
  - The held PCSrcE/lwStall take effect on this release cycle; no pending flag is needed.
- ERROR: all stalls=1, flushD=flushE=0, forwards 00, mem_timeout=1. Only rst_n exits.
- Latency: forwarding/stall/flush are zero-cycle combinational; state changes one cycle after the cause.

Optional Feature:
- Macro HAZARD_PERF_EN.
  - Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
    - perf_stall_cycles increments on every cycle with stallD=1 in RUN or MEM_WAIT.
    - perf_flush_count increments on every RUN/MEM_WAIT output cycle with flushD=1.
  - Undefined: these ports and counters do not exist.

Decomposition:
- rv32i_pkg:
  - hazard_state_t enum {INIT, RUN, MEM_WAIT, ERROR}.
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}.
  - Existing DPW.
- Sub-module fwd_sel_unit (combinational, one instance per operand): inputs RsE, RdM, RdW, regwriteM, regwriteW; output fwd_sel_t.

Test Plan:
- Reset release, INIT_CYCLES=3 -> stallF=flushD=flushE=1 exactly 3 cycles after rst_n rises, then all 0 with idle inputs.
- Forwarding: Rs1E=5, RdM=RdW=5, both regwrite=1 -> forwardAE=10; regwriteM=0 -> 01; RdM=RdW=0 -> 00; Rs2E=9, RdW=9 -> forwardBE=01.
- Load-use: resultsrcE=1, RdE=7, Rs2D=7 -> stallF=stallD=flushE=1, flushD=0; RdE=0 -> no stall.
- Branch: PCSrcE=1, resultsrcE=0 -> flushD=flushE=1, stalls 0, one cycle only.
- Memory wait: mem_req_M=1, mem_ready=0 for 4 cycles with PCSrcE=1 held -> all stalls 1, no flushes. mem_ready=1 -> stalls 0, flushD=flushE=1 that cycle, then RUN.
- Timeout: MEM_TIMEOUT=8, mem_ready never rises -> ERROR after 1+8 stalled cycles, mem_timeout=1 and stays. Assert rst_n=0 mid-ERROR -> immediately INIT, mem_timeout=0.
